imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Responder end of the fetch-stage instruction interface: takes the word address the fetch
//  stage drives each cycle and returns the instruction word on the following cycle.
//  Backed by one LINE_WORDS-word line buffer, refilled from the external instruction bus
//  (req/gnt/rvalid, one outstanding beat). On a miss it asserts stall_o, which the core
//  drives into fetch enable low, until the line is filled.
// PARAMETERS
//  LINE_WORDS  4   words per line buffer; power of 2, 2..16; OFS=$clog2(LINE_WORDS)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   reset, asynchronous, active-low
//  flush_i       in   1   invalidate line buffer (fence.i / context switch)
//  iaddr_i       in   32  fetch address; bits [1:0] ignored
//  stall_o       out  1   comb; 1 = request at iaddr_i not accepted this cycle
//  idata_o       out  32  instruction for the address accepted in the previous cycle
//  fault_o       out  1   registered; 1 = idata_o belongs to a faulted fetch
//  bus_req_o     out  1   bus request
//  bus_addr_o    out  32  bus word address, bits [1:0]=0
//  bus_gnt_i     in   1   request accepted this cycle
//  bus_rvalid_i  in   1   read data valid
//  bus_rdata_i   in   32  read data
//  bus_err_i     in   1   with rvalid: beat faulted
// BEHAVIOUR
//  Address split: tag=iaddr_i[31:OFS+2], word=iaddr_i[OFS+1:2]
//  - hit = valid && tag==line_tag && state==IDLE && !flush_i
//  Reset values: stall_o=1 (line invalid), idata_o=32'h00000013, fault_o=0, bus_req_o=0,
//  bus_addr_o=0, valid=0, state=IDLE.
//  Accept: stall_o = !(hit || err_hit)
//  - Hit in cycle N -> cycle N+1: idata_o=line[word], fault_o=0.
//  - Stalled cycle: idata_o and fault_o hold.
//  Miss in IDLE with !flush_i -> REQ:
//  - Latch fill_tag=tag.
//  - cnt=0; base word=0 (see CONFIGURATION).
//  FSM:
//  - IDLE -> REQ on miss.
//  - REQ: bus_req_o=1, bus_addr_o={fill_tag, (base+cnt) mod LINE_WORDS, 2'b00}.
//    gnt -> WAIT.
//  - WAIT: bus_req_o=0. On rvalid && !err:
//    line[(base+cnt) mod LINE_WORDS] <= rdata; cnt++.
//    If cnt==LINE_WORDS-1 -> IDLE, with valid <= !discard and line_tag <= fill_tag.
//    Otherwise -> REQ.
//  - WAIT, rvalid && err -> ERR:
//    valid<=0; err_addr<=faulting beat address.
//    Discard the rest of the line; no further requests.
//  - ERR: err_hit = iaddr_i[31:2]==err_addr[31:2].
//    Accepted once: next cycle idata_o=32'h00000000, fault_o=1; state -> IDLE.
//    Other addresses stall, then go to IDLE (a miss restarts normally).
//  - bus_req_o may stay high across several cycles without gnt; bus_addr_o stays stable.
//  Flush:
//  - IDLE: valid<=0 next edge; the same-cycle hit is suppressed (flush wins).
//  - REQ/WAIT: set discard. Outstanding beat still completes (bus rule).
//    At end of fill: valid stays 0, discard cleared. Requests are not cut short.
//  - ERR: -> IDLE.
//  Simultaneous rvalid and gnt cannot occur (one outstanding); bus_gnt_i is ignored outside REQ.
//  Async reset mid-fill: all state reset. Outstanding bus beats after reset are ignored;
//  rvalid outside WAIT is dropped.
//  Miss latency (no wait states, gnt same cycle as req): 2*LINE_WORDS+1 stall cycles before
//  accept, then data the next cycle.
// CONFIGURATION
//  IMEM_CRITICAL_WORD_FIRST_EN
//  - Defined: fill starts at base=requested word and wraps mod LINE_WORDS.
//    The requested word is accepted the cycle after its beat lands (early restart).
//    stall_o = 0 for that word while the rest fills; other words stall until their beat lands.
//  - Undefined: base=0; stall until the full line is valid.
// TESTING
//  1. Reset, iaddr_i=0x100, bus 0-wait, rdata=addr^0xA5A5A5A5.
//     -> stall_o=1 for 9 cycles; bus addrs 0x100,104,108,10C; then idata_o=0xA5A5A4A5.
//  2. Line filled at 0x100; sweep 0x100..0x10C.
//     -> stall_o=0 every cycle; idata_o matches with 1-cycle latency; no bus_req_o.
//  3. Miss 0x208, bus_err_i on the 2nd beat (0x204 without macro).
//     -> no further req; iaddr_i=0x204 gives idata_o=0, fault_o=1;
//     -> re-fetch of 0x208 restarts a fill at 0x200.
//  4. flush_i during WAIT of beat 2.
//     -> beat completes, fill finishes, valid=0; next access to same line re-misses.
//  5. IMEM_CRITICAL_WORD_FIRST_EN, miss 0x30C.
//     -> bus order 0x30C,300,304,308; stall_o drops after the first beat;
//     -> idata_o correct; a 0x300 access stalls until its beat lands.
//  6. gnt held low 5 cycles in REQ.
//     -> bus_req_o and bus_addr_o stable throughout; reset_n pulse mid-fill -> idata_o=0x13, bus_req_o=0.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder backed by one refillable line buffer (req/gnt/rvalid bus).
// Optional IMEM_CRITICAL_WORD_FIRST_EN: critical-word-first fill with early restart.
module imem_responder #(
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush_i,
   input  logic [31:0] iaddr_i,
   output logic        stall_o,
   output logic [31:0] idata_o,
   output logic        fault_o,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i
);
   localparam int OFS   = $clog2(LINE_WORDS);
   localparam int TAG_W = 30 - OFS;
   localparam logic [OFS-1:0] LAST_BEAT = OFS'(LINE_WORDS - 1);
   localparam logic [OFS-1:0] ONE_OFS   = OFS'(1);
   localparam logic [31:0]    NOP_INSN  = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t           state_r;
   logic             valid_r;
   logic             discard_r;
   logic [TAG_W-1:0] line_tag_r;
   logic [TAG_W-1:0] fill_tag_r;
   logic [OFS-1:0]   idx_r;
   logic [OFS-1:0]   cnt_r;
   logic [29:0]      err_addr_r;
   logic [31:0]      line_r [LINE_WORDS];
   logic [31:0]      idata_r;
   logic             fault_r;
   logic             bus_req_r;
   logic [31:0]      bus_addr_r;

   logic [TAG_W-1:0] tag_s;
   logic [OFS-1:0]   word_s;
   logic [OFS-1:0]   start_idx_s;
   logic [OFS-1:0]   next_idx_s;
   logic             hit_s;
   logic             err_hit_s;
   logic             early_hit_s;
   logic             discard_s;
   logic             unused_s;

   assign tag_s      = iaddr_i[31:OFS+2];
   assign word_s     = iaddr_i[OFS+1:2];
   assign unused_s   = ^iaddr_i[1:0];
   assign next_idx_s = idx_r + ONE_OFS;
   assign discard_s  = discard_r | flush_i;

   assign hit_s     = valid_r && (tag_s == line_tag_r) && (state_r == S_IDLE) && !flush_i;
   assign err_hit_s = (state_r == S_ERR) && (iaddr_i[31:2] == err_addr_r);

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
   // Words already landed in the current fill; lets the core restart before the line completes.
   logic [LINE_WORDS-1:0] landed_r;

   assign start_idx_s = word_s;
   assign early_hit_s = ((state_r == S_REQ) || (state_r == S_WAIT)) && !discard_s &&
                        (tag_s == fill_tag_r) && landed_r[word_s];

   // Track landed beats; cleared at the start of every fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         landed_r <= '0;
      end else if ((state_r == S_IDLE) && !flush_i && !hit_s) begin
         landed_r <= '0;
      end else if ((state_r == S_WAIT) && bus_rvalid_i && !bus_err_i) begin
         landed_r[idx_r] <= 1'b1;
      end else if (state_r == S_ERR) begin
         landed_r <= '0;
      end
   end
`else
   assign start_idx_s = '0;
   assign early_hit_s = 1'b0;
`endif

   assign stall_o    = !(hit_s || err_hit_s || early_hit_s);
   assign idata_o    = idata_r;
   assign fault_o    = fault_r;
   assign bus_req_o  = bus_req_r;
   assign bus_addr_o = bus_addr_r;

   // Fill FSM, line storage and registered fetch/bus outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= S_IDLE;
         valid_r    <= 1'b0;
         discard_r  <= 1'b0;
         line_tag_r <= '0;
         fill_tag_r <= '0;
         idx_r      <= '0;
         cnt_r      <= '0;
         err_addr_r <= 30'd0;
         idata_r    <= NOP_INSN;
         fault_r    <= 1'b0;
         bus_req_r  <= 1'b0;
         bus_addr_r <= 32'd0;
         for (int i = 0; i < LINE_WORDS; i++) begin
            line_r[i] <= 32'd0;
         end
      end else begin
         if (hit_s || early_hit_s) begin
            idata_r <= line_r[word_s];
            fault_r <= 1'b0;
         end else if (err_hit_s) begin
            idata_r <= 32'd0;
            fault_r <= 1'b1;
         end

         case (state_r)
            S_IDLE: begin
               if (flush_i) begin
                  valid_r <= 1'b0;
               end else if (!hit_s) begin
                  state_r    <= S_REQ;
                  valid_r    <= 1'b0;
                  discard_r  <= 1'b0;
                  fill_tag_r <= tag_s;
                  idx_r      <= start_idx_s;
                  cnt_r      <= '0;
                  bus_req_r  <= 1'b1;
                  bus_addr_r <= {tag_s, start_idx_s, 2'b00};
               end
            end
            S_REQ: begin
               if (flush_i) begin
                  discard_r <= 1'b1;
               end
               if (bus_gnt_i) begin
                  state_r   <= S_WAIT;
                  bus_req_r <= 1'b0;
               end
            end
            S_WAIT: begin
               if (flush_i) begin
                  discard_r <= 1'b1;
               end
               if (bus_rvalid_i && bus_err_i) begin
                  // Faulting beat: drop the rest of the line and remember where it failed.
                  state_r    <= S_ERR;
                  valid_r    <= 1'b0;
                  discard_r  <= 1'b0;
                  err_addr_r <= bus_addr_r[31:2];
               end else if (bus_rvalid_i) begin
                  line_r[idx_r] <= bus_rdata_i;
                  if (cnt_r == LAST_BEAT) begin
                     state_r    <= S_IDLE;
                     valid_r    <= !discard_s;
                     line_tag_r <= fill_tag_r;
                     discard_r  <= 1'b0;
                  end else begin
                     state_r    <= S_REQ;
                     idx_r      <= next_idx_s;
                     cnt_r      <= cnt_r + ONE_OFS;
                     bus_req_r  <= 1'b1;
                     bus_addr_r <= {fill_tag_r, next_idx_s, 2'b00};
                  end
               end
            end
            S_ERR: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r   <= S_IDLE;
               valid_r   <= 1'b0;
               bus_req_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder with a zero-wait bus model.
module tb_imem_responder;
   localparam logic [31:0] XORV = 32'hA5A5_A5A5;

   logic        clk          = 1'b0;
   logic        reset_n      = 1'b0;
   logic        flush_i      = 1'b0;
   logic [31:0] iaddr_i      = 32'd0;
   logic        bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i  = 32'd0;
   logic        bus_err_i    = 1'b0;
   logic        gnt_en       = 1'b1;
   logic        err_arm      = 1'b0;
   logic [31:0] err_at       = 32'd0;
   logic        stall_o, fault_o, bus_req_o, bus_gnt_i;
   logic [31:0] idata_o, bus_addr_o;
   logic [31:0] beat_q [$];
   int          errors = 0;
   int          checks = 0;
   int          n;

   typedef struct {
      logic [31:0] addr;
      logic        flush;
      logic        stall;
      logic [31:0] data;
   } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   imem_responder #(.LINE_WORDS(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush_i),
      .iaddr_i     (iaddr_i),
      .stall_o     (stall_o),
      .idata_o     (idata_o),
      .fault_o     (fault_o),
      .bus_req_o   (bus_req_o),
      .bus_addr_o  (bus_addr_o),
      .bus_gnt_i   (bus_gnt_i),
      .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i (bus_rdata_i),
      .bus_err_i   (bus_err_i)
   );

   assign bus_gnt_i = bus_req_o & gnt_en;

   // Bus slave: grant when enabled, answer the next cycle, log granted addresses.
   always @(posedge clk) begin
      bus_rvalid_i <= bus_req_o & bus_gnt_i;
      bus_rdata_i  <= bus_addr_o ^ XORV;
      bus_err_i    <= err_arm & (bus_addr_o == err_at);
      if (bus_req_o && bus_gnt_i) beat_q.push_back(bus_addr_o);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_stall(input int limit, output int cnt);
      cnt = 0;
      #1;
      while (stall_o === 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{32'h100, 1'b0, 1'b0, 32'hA5A5_A4A5};
      vt[1] = '{32'h104, 1'b0, 1'b0, 32'hA5A5_A4A1};
      vt[2] = '{32'h108, 1'b0, 1'b0, 32'hA5A5_A4AD};
      vt[3] = '{32'h10C, 1'b0, 1'b0, 32'hA5A5_A4A9};
      vt[4] = '{32'h108, 1'b0, 1'b0, 32'hA5A5_A4AD};
      vt[5] = '{32'h100, 1'b0, 1'b0, 32'hA5A5_A4A5};
      vt[6] = '{32'h10C, 1'b0, 1'b0, 32'hA5A5_A4A9};
      vt[7] = '{32'h104, 1'b1, 1'b1, 32'hA5A5_A4A9};

      // 1: reset values, then cold miss at 0x100
      iaddr_i = 32'h100;
      #12;
      check1("rst_stall", stall_o, 1'b1);
      check("rst_idata", idata_o, 32'h0000_0013);
      check1("rst_fault", fault_o, 1'b0);
      check1("rst_req", bus_req_o, 1'b0);
      check("rst_addr", bus_addr_o, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      count_stall(40, n);
      check("miss_latency", n, 32'd9);
      tick();
      check("miss_idata", idata_o, 32'hA5A5_A4A5);
      check("miss_beats", beat_q.size(), 32'd4);
      check("miss_beat0", beat_q[0], 32'h100);
      check("miss_beat1", beat_q[1], 32'h104);
      check("miss_beat2", beat_q[2], 32'h108);
      check("miss_beat3", beat_q[3], 32'h10C);

      // 2: back-to-back hits, ending with a flush that suppresses the hit
      beat_q.delete();
      for (int i = 0; i < 8; i++) begin
         iaddr_i = vt[i].addr;
         flush_i = vt[i].flush;
         #1;
         check1($sformatf("vec%0d_stall", i), stall_o, vt[i].stall);
         tick();
         check($sformatf("vec%0d_idata", i), idata_o, vt[i].data);
         check1($sformatf("vec%0d_req", i), bus_req_o, 1'b0);
      end
      flush_i = 1'b0;
      check("hit_no_beats", beat_q.size(), 32'd0);

      // 3: bus error on the 2nd beat of a fill for 0x208
      err_at  = 32'h204;
      err_arm = 1'b1;
      iaddr_i = 32'h208;
      n = 0;
      while (!(bus_rvalid_i && bus_err_i) && n < 30) begin
         tick();
         n++;
      end
      check1("err_beat_seen", bus_rvalid_i & bus_err_i, 1'b1);
      iaddr_i = 32'h204;
      err_arm = 1'b0;
      tick();
      check1("err_accept", stall_o, 1'b0);
      check1("err_no_req", bus_req_o, 1'b0);
      tick();
      check("err_idata", idata_o, 32'd0);
      check1("err_fault", fault_o, 1'b1);
      check("err_beats", beat_q.size(), 32'd2);
      check("err_beat1", beat_q[1], 32'h204);
      iaddr_i = 32'h208;
      beat_q.delete();
      count_stall(40, n);
      check("refill_latency", n, 32'd9);
      check("refill_beat0", beat_q[0], 32'h200);
      tick();
      check("refill_idata", idata_o, 32'hA5A5_A7AD);
      check1("refill_fault", fault_o, 1'b0);

      // 4: flush during the WAIT of beat 2 -> fill completes, line stays invalid
      iaddr_i = 32'h400;
      beat_q.delete();
      n = 0;
      while (!(bus_req_o && bus_addr_o == 32'h404) && n < 30) begin
         tick();
         n++;
      end
      check1("fl_req2_seen", bus_req_o, 1'b1);
      tick();
      flush_i = 1'b1;
      check1("fl_beat_inflight", bus_rvalid_i, 1'b1);
      tick();
      flush_i = 1'b0;
      n = 0;
      while (beat_q.size() < 5 && n < 40) begin
         tick();
         n++;
      end
      check("fl_beats", beat_q.size(), 32'd5);
      check("fl_beat2", beat_q[2], 32'h408);
      check("fl_beat3", beat_q[3], 32'h40C);
      check("fl_remiss", beat_q[4], 32'h400);
      count_stall(40, n);
      check1("fl_refill_done", stall_o, 1'b0);
      tick();
      check("fl_idata", idata_o, 32'hA5A5_A1A5);

      // 5: miss at 0x30C, order depends on critical-word-first build
      iaddr_i = 32'h30C;
      beat_q.delete();
      count_stall(40, n);
`ifdef IMEM_CRITICAL_WORD_FIRST_EN
      check("cwf_latency", n, 32'd3);
      check("cwf_beat0", beat_q[0], 32'h30C);
      tick();
      check("cwf_idata", idata_o, 32'hA5A5_A6A9);
      iaddr_i = 32'h300;
      #1;
      check1("cwf_300_stall", stall_o, 1'b1);
      tick();
      check1("cwf_300_accept", stall_o, 1'b0);
      tick();
      check("cwf_300_idata", idata_o, 32'hA5A5_A6A5);
      n = 0;
      while (beat_q.size() < 4 && n < 20) begin
         tick();
         n++;
      end
      check("cwf_beat1", beat_q[1], 32'h300);
      check("cwf_beat2", beat_q[2], 32'h304);
      check("cwf_beat3", beat_q[3], 32'h308);
      tick();
      tick();
`else
      check("m30c_latency", n, 32'd9);
      tick();
      check("m30c_idata", idata_o, 32'hA5A5_A6A9);
      check("m30c_beat0", beat_q[0], 32'h300);
      check("m30c_beat3", beat_q[3], 32'h30C);
      iaddr_i = 32'h300;
      #1;
      check1("m30c_300_hit", stall_o, 1'b0);
      tick();
      check("m30c_300_idata", idata_o, 32'hA5A5_A6A5);
`endif

      // 6: grant withheld for 5 cycles, then async reset mid-fill
      iaddr_i = 32'h500;
      gnt_en  = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check1($sformatf("hold%0d_req", i), bus_req_o, 1'b1);
         check($sformatf("hold%0d_addr", i), bus_addr_o, 32'h500);
         tick();
      end
      gnt_en = 1'b1;
      tick();
      reset_n = 1'b0;
      #1;
      check("arst_idata", idata_o, 32'h0000_0013);
      check1("arst_req", bus_req_o, 1'b0);
      check1("arst_stall", stall_o, 1'b1);
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      beat_q.delete();
      count_stall(40, n);
`ifdef IMEM_CRITICAL_WORD_FIRST_EN
      check("post_rst_latency", n, 32'd3);
`else
      check("post_rst_latency", n, 32'd9);
`endif
      check("post_rst_beat0", beat_q[0], 32'h500);
      tick();
      check("post_rst_idata", idata_o, 32'hA5A5_A0A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
